// File: rtl/avr_pkg.sv
// Shared program-memory constants and the loader state encoding.
// Checksum acceptance in CHECK depends on AVR_PMEM_LOADER_CKSUM_EN.
package avr_pkg;

  localparam int PMEM_ADDR_W = 9;
  localparam int PMEM_DEPTH  = 512;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } loader_state_t;

  // States in which the loader takes a byte from the stream.
  function automatic logic state_accepts(input loader_state_t s);
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI: state_accepts = 1'b1;
`ifdef AVR_PMEM_LOADER_CKSUM_EN
      ST_CHECK:                                     state_accepts = 1'b1;
`endif
      default:                                      state_accepts = 1'b0;
    endcase
  endfunction

  function automatic logic state_holds_cpu(input loader_state_t s);
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI,
      ST_CHECK, ST_ERR: state_holds_cpu = 1'b1;
      default:          state_holds_cpu = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/avr_pmem_loader.sv
// Streams a length-prefixed little-endian AVR image into program memory.
// Define AVR_PMEM_LOADER_CKSUM_EN to require a trailing zero-sum checksum byte.
module avr_pmem_loader #(
  parameter int ADDR_W = avr_pkg::PMEM_ADDR_W,
  parameter int DEPTH  = avr_pkg::PMEM_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pmem_we,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [15:0]       pmem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  import avr_pkg::*;

  loader_state_t     r_state;
  loader_state_t     w_state_next;
  logic              w_start_load;
  logic              w_xfer;
  logic              w_last_word;
  logic [15:0]       w_len_full;

  logic              r_in_ready;
  logic              r_pmem_we;
  logic [ADDR_W-1:0] r_pmem_addr;
  logic [15:0]       r_pmem_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_error;

  logic [15:0]       r_len;
  logic [7:0]        r_lo;
  logic [ADDR_W-1:0] r_idx;

`ifdef AVR_PMEM_LOADER_CKSUM_EN
  logic [7:0]        r_sum;
  logic [7:0]        w_sum_final;
  assign w_sum_final = r_sum + in_data;
`endif

  assign w_xfer      = in_valid & r_in_ready;
  assign w_len_full  = {in_data, r_len[7:0]};
  // The index stops at N-1, so the last word is recognised by equality.
  assign w_last_word = (16'(r_idx) == (r_len - 16'd1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_start_load = 1'b1;
          w_state_next = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_xfer) w_state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_xfer) begin
          if (w_len_full > 16'(DEPTH))  w_state_next = ST_ERR;
          else if (w_len_full == 16'd0) w_state_next = ST_CHECK;
          else                          w_state_next = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (w_xfer) w_state_next = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        if (w_xfer) w_state_next = w_last_word ? ST_CHECK : ST_DATA_LO;
      end
      ST_CHECK: begin
`ifdef AVR_PMEM_LOADER_CKSUM_EN
        if (w_xfer) w_state_next = (w_sum_final == 8'h00) ? ST_DONE : ST_ERR;
`else
        w_state_next = ST_DONE;
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_in_ready   <= 1'b0;
      r_pmem_we    <= 1'b0;
      r_pmem_addr  <= '0;
      r_pmem_wdata <= '0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_len        <= '0;
      r_lo         <= '0;
      r_idx        <= '0;
    end else begin
      r_pmem_we  <= 1'b0;
      r_in_ready <= state_accepts(w_state_next);
      r_cpu_hold <= state_holds_cpu(w_state_next);
      r_done     <= (w_state_next == ST_DONE);
      r_error    <= (w_state_next == ST_ERR);
      if (w_start_load) begin
        r_pmem_addr <= '0;
        r_idx       <= '0;
        r_len       <= '0;
      end
      if (w_xfer) begin
        case (r_state)
          ST_LEN_LO:  r_len[7:0]  <= in_data;
          ST_LEN_HI:  r_len[15:8] <= in_data;
          ST_DATA_LO: r_lo        <= in_data;
          ST_DATA_HI: begin
            r_pmem_we    <= 1'b1;
            r_pmem_wdata <= {in_data, r_lo};
            r_pmem_addr  <= r_idx;
            if (!w_last_word) r_idx <= r_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef AVR_PMEM_LOADER_CKSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               r_sum <= '0;
    else if (w_start_load) r_sum <= '0;
    else if (w_xfer)       r_sum <= w_sum_final;
  end
`endif

  assign in_ready   = r_in_ready;
  assign pmem_we    = r_pmem_we;
  assign pmem_addr  = r_pmem_addr;
  assign pmem_wdata = r_pmem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_avr_pmem_loader.sv
// Randomised bench for avr_pmem_loader; expectations come from parsing the
// byte stream directly (length prefix, LE words, optional zero-sum checksum).
module tb_avr_pmem_loader;

  localparam int DEPTH = 512;
`ifdef AVR_PMEM_LOADER_CKSUM_EN
  localparam bit CKSUM = 1'b1;
`else
  localparam bit CKSUM = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        pmem_we;
  logic [8:0]  pmem_addr;
  logic [15:0] pmem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stim_q[$];
  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];
  bit          exp_done;
  bit          exp_error;
  int          exp_lat;

  avr_pmem_loader dut (
    .CLK(CLK), .RST(RST), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pmem_we(pmem_we), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (pmem_we) got_q.push_back({pmem_addr, pmem_wdata});
  end

  // Reference: what a correct loader does with the bytes in stim_q.
  task automatic model_expect();
    int n;
    logic [7:0] sum;
    exp_q.delete();
    n = {16'd0, stim_q[1], stim_q[0]};
    if (n > DEPTH) begin
      exp_error = 1'b1; exp_done = 1'b0; exp_lat = 1;
      return;
    end
    for (int i = 0; i < n; i++)
      exp_q.push_back({9'(i), stim_q[3 + 2*i], stim_q[2 + 2*i]});
    sum = 8'h00;
    foreach (stim_q[i]) sum = sum + stim_q[i];
    exp_error = CKSUM && (sum != 8'h00);
    exp_done  = !exp_error;
    exp_lat   = CKSUM ? 1 : 2;
  endtask

  task automatic append_cksum(input bit bad);
    logic [7:0] s;
    if (CKSUM) begin
      s = 8'h00;
      foreach (stim_q[i]) s = s + stim_q[i];
      s = 8'h00 - s;
      if (bad) s = s + 8'($urandom_range(1, 255));
      stim_q.push_back(s);
    end
  endtask

  task automatic build_image(input int n, input bit bad);
    stim_q.delete();
    stim_q.push_back(n[7:0]);
    stim_q.push_back(n[15:8]);
    for (int i = 0; i < 2*n; i++) stim_q.push_back(8'($urandom));
    append_cksum(bad);
  endtask

  task automatic pulse_start(input bit with_valid);
    @(negedge CLK);
    start = 1'b1; in_valid = with_valid; in_data = 8'hEE;
    @(negedge CLK);
    start = 1'b0; in_valid = 1'b0;
    got_q.delete();
  endtask

  // gap_mode 0: always valid, 1: valid every other cycle, 2: random gaps.
  task automatic drive_stream(input int gap_mode, input int start_at, input int limit,
                              output bit to);
    int idx, cyc;
    bit v;
    idx = 0; cyc = 0; to = 1'b0;
    while (idx < limit && !to) begin
      @(negedge CLK);
      start = (idx == start_at);
      case (gap_mode)
        1:       v = ((cyc % 2) == 0);
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      in_valid = v;
      in_data  = v ? stim_q[idx] : 8'($urandom);
      if (v && in_ready) idx++;
      cyc++;
      if (cyc > 8000) to = 1'b1;
    end
  endtask

  task automatic wait_end(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      in_valid = 1'b0; start = 1'b0;
      lat++;
    end while (!(done || error) && lat < 50);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({in_ready, pmem_we, pmem_addr, pmem_wdata, cpu_hold, done, error} !== 30'd0) begin
      n_errors++; $display("FAIL reset_hold: outputs %h want 0",
        {in_ready, pmem_we, pmem_addr, pmem_wdata, cpu_hold, done, error});
    end
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_data = 8'h5A;
      n_checks++;
      if ({in_ready, cpu_hold, done, error} !== 4'b0000) begin
        n_errors++; $display("FAIL idle_status: {rdy,hold,done,err} %b want 0000",
          {in_ready, cpu_hold, done, error});
      end
    end
    in_valid = 1'b0;
    $display("reset: outputs idle after release");
  endtask

  task automatic test_basic();
    bit to;
    int lat, d;
    for (int g = 0; g < 2; g++) begin
      stim_q = '{8'h03, 8'h00, 8'h0C, 8'h94, 8'h34, 8'h00, 8'hFF, 8'hCF};
      append_cksum(1'b0);
      model_expect();
      pulse_start(1'b0);
      n_checks++;
      if ({cpu_hold, in_ready, done, error} !== 4'b1100) begin
        n_errors++; $display("FAIL basic_start: {hold,rdy,done,err} %b want 1100",
          {cpu_hold, in_ready, done, error});
      end
      drive_stream(g, -1, stim_q.size(), to);
      wait_end(lat);
      d = first_diff();
      $display("load basic gap=%0d N=3 writes=%0d done=%0b error=%0b lat=%0d",
               g, got_q.size(), done, error, lat);
      n_checks++;
      if (to !== 1'b0) begin n_errors++; $display("FAIL basic_timeout: stream stuck"); end
      n_checks++;
      if ({done, error, cpu_hold, in_ready} !== {exp_done, exp_error, exp_error, 1'b0}) begin
        n_errors++; $display("FAIL basic_status: {done,err,hold,rdy} %b want %b",
          {done, error, cpu_hold, in_ready}, {exp_done, exp_error, exp_error, 1'b0});
      end
      n_checks++;
      if (lat !== exp_lat) begin n_errors++; $display("FAIL basic_latency: %0d want %0d", lat, exp_lat); end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
        n_errors++; $display("FAIL basic_count: %0d writes want %0d", got_q.size(), exp_q.size());
      end
      n_checks++;
      if (d !== -1) begin
        n_errors++; $display("FAIL basic_data: write %0d got %h want %h", d, got_q[d], exp_q[d]);
      end
    end
  endtask

  task automatic test_oversize();
    bit to;
    int lat, d;
    stim_q = '{8'h01, 8'h02};
    model_expect();
    pulse_start(1'b1);
    drive_stream(0, -1, stim_q.size(), to);
    wait_end(lat);
    $display("load oversize N=513 writes=%0d done=%0b error=%0b lat=%0d",
             got_q.size(), done, error, lat);
    n_checks++;
    if ({done, error, cpu_hold, in_ready} !== 4'b0110) begin
      n_errors++; $display("FAIL oversize_status: {done,err,hold,rdy} %b want 0110",
        {done, error, cpu_hold, in_ready});
    end
    n_checks++;
    if (lat !== exp_lat) begin n_errors++; $display("FAIL oversize_latency: %0d want %0d", lat, exp_lat); end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (got_q.size() !== 0 || error !== 1'b1) begin
      n_errors++; $display("FAIL oversize_writes: %0d writes err=%b want 0 writes err=1",
        got_q.size(), error);
    end
    build_image(1, 1'b0);
    model_expect();
    pulse_start(1'b1);
    drive_stream(0, -1, stim_q.size(), to);
    wait_end(lat);
    d = first_diff();
    $display("load recover N=1 writes=%0d done=%0b error=%0b lat=%0d",
             got_q.size(), done, error, lat);
    n_checks++;
    if ({done, error, cpu_hold} !== 3'b100 || to) begin
      n_errors++; $display("FAIL recover_status: {done,err,hold} %b to=%b want 100 to=0",
        {done, error, cpu_hold}, to);
    end
    n_checks++;
    if (got_q.size() !== 1 || d !== -1) begin
      n_errors++; $display("FAIL recover_data: %0d writes diff@%0d want 1 writes", got_q.size(), d);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int lat, d;
    build_image(4, 1'b0);
    model_expect();
    pulse_start(1'b0);
    drive_stream(0, -1, 6, to);
    @(posedge CLK); #1;
    n_checks++;
    if ({pmem_we, pmem_addr, pmem_wdata} !== {1'b1, 9'd1, exp_q[1][15:0]}) begin
      n_errors++; $display("FAIL midreset_inflight: %h want %h",
        {pmem_we, pmem_addr, pmem_wdata}, {1'b1, 9'd1, exp_q[1][15:0]});
    end
    RST = 1'b1; in_valid = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, pmem_we, pmem_addr, pmem_wdata, cpu_hold, done, error} !== 30'd0) begin
      n_errors++; $display("FAIL midreset_outputs: %h want 0",
        {in_ready, pmem_we, pmem_addr, pmem_wdata, cpu_hold, done, error});
    end
    @(negedge CLK);
    n_checks++;
    if (got_q.size() !== 1) begin
      n_errors++; $display("FAIL midreset_dropped: %0d writes seen want 1", got_q.size());
    end
    RST = 1'b0;
    pulse_start(1'b0);
    drive_stream(2, -1, stim_q.size(), to);
    wait_end(lat);
    d = first_diff();
    $display("load reload N=4 writes=%0d done=%0b error=%0b lat=%0d",
             got_q.size(), done, error, lat);
    n_checks++;
    if ({done, error, cpu_hold} !== 3'b100 || to || lat !== exp_lat) begin
      n_errors++; $display("FAIL reload_status: {done,err,hold} %b lat %0d want 100 lat %0d",
        {done, error, cpu_hold}, lat, exp_lat);
    end
    n_checks++;
    if (got_q.size() !== 4 || d !== -1) begin
      n_errors++; $display("FAIL reload_data: %0d writes diff@%0d want 4 writes", got_q.size(), d);
    end
  endtask

  task automatic test_max();
    bit to;
    int lat, d;
    build_image(DEPTH, 1'b0);
    model_expect();
    pulse_start(1'b0);
    drive_stream(2, 300, stim_q.size(), to);
    wait_end(lat);
    d = first_diff();
    $display("load max N=%0d writes=%0d done=%0b error=%0b lat=%0d",
             DEPTH, got_q.size(), done, error, lat);
    n_checks++;
    if ({done, error, cpu_hold} !== 3'b100 || to || lat !== exp_lat) begin
      n_errors++; $display("FAIL max_status: {done,err,hold} %b lat %0d want 100 lat %0d",
        {done, error, cpu_hold}, lat, exp_lat);
    end
    n_checks++;
    if (got_q.size() !== DEPTH) begin
      n_errors++; $display("FAIL max_count: %0d writes want %0d", got_q.size(), DEPTH);
    end
    n_checks++;
    if (d !== -1) begin
      n_errors++; $display("FAIL max_data: write %0d got %h want %h", d, got_q[d], exp_q[d]);
    end
    n_checks++;
    if (got_q[$][24:16] !== 9'd511) begin
      n_errors++; $display("FAIL max_last_addr: %0d want 511", got_q[$][24:16]);
    end
  endtask

  task automatic test_random();
    bit to;
    int lat, d, n, g;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, 24);
      g = $urandom_range(0, 2);
      build_image(n, $urandom_range(0, 3) == 0);
      model_expect();
      pulse_start($urandom_range(0, 1) == 1);
      drive_stream(g, $urandom_range(2, 10), stim_q.size(), to);
      wait_end(lat);
      d = first_diff();
      $display("load random N=%0d gap=%0d writes=%0d done=%0b error=%0b lat=%0d",
               n, g, got_q.size(), done, error, lat);
      n_checks++;
      if ({done, error, cpu_hold} !== {exp_done, exp_error, exp_error} || to) begin
        n_errors++; $display("FAIL random_status: {done,err,hold} %b to=%b want %b",
          {done, error, cpu_hold}, to, {exp_done, exp_error, exp_error});
      end
      n_checks++;
      if (lat !== exp_lat) begin n_errors++; $display("FAIL random_latency: %0d want %0d", lat, exp_lat); end
      n_checks++;
      if (got_q.size() !== exp_q.size() || d !== -1) begin
        n_errors++; $display("FAIL random_data: %0d writes diff@%0d want %0d writes",
          got_q.size(), d, exp_q.size());
      end
    end
  endtask

`ifdef AVR_PMEM_LOADER_CKSUM_EN
  task automatic test_cksum();
    bit to;
    int lat;
    logic [7:0] ck_byte;
    for (int k = 0; k < 2; k++) begin
      ck_byte = 8'(k);
      stim_q = '{8'h01, 8'h00, 8'hAA, 8'h55};
      stim_q.push_back(ck_byte);
      model_expect();
      pulse_start(1'b0);
      drive_stream(0, -1, stim_q.size(), to);
      wait_end(lat);
      $display("load cksum=%02h writes=%0d done=%0b error=%0b lat=%0d",
               ck_byte, got_q.size(), done, error, lat);
      n_checks++;
      if ({done, error, cpu_hold} !== {k == 0, k == 1, k == 1} || to) begin
        n_errors++; $display("FAIL cksum_status: {done,err,hold} %b want %b",
          {done, error, cpu_hold}, {k == 0, k == 1, k == 1});
      end
      n_checks++;
      if (got_q.size() !== 1 || got_q[0] !== {9'd0, 16'h55AA}) begin
        n_errors++; $display("FAIL cksum_write: %0d writes first %h want 1 write 00055aa",
          got_q.size(), got_q[0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_oversize();
    test_reset_mid();
    test_max();
    test_random();
`ifdef AVR_PMEM_LOADER_CKSUM_EN
    test_cksum();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
